// File: rtl/spi_pkg.sv
// Shared definitions for the multi-channel SPI master.
//   state_t    : controller phases IDLE -> SETUP -> XFER -> HOLD
//   MODE0..3   : SPI mode encodings as {cpol, cpha}
//   clog2_min1 : select-bus width that never collapses to zero bits
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer and SCLK edge sequencer.
//   i_clk, i_reset : system clock, synchronous active-high reset
//   i_run          : counter runs while high, held at zero while low
//   i_edge_en      : high while SCLK edges are being generated
//   i_div          : latched divider, half period H = i_div + 1 cycles
//   o_tick         : one-cycle pulse at the end of every half period
//   o_lead/o_trail : tick that produces a leading / trailing SCLK edge
//   o_last         : tick that produces the final (2*DATA_W-th) edge
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run,
    input  logic             i_edge_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick,
    output logic             o_lead,
    output logic             o_trail,
    output logic             o_last
);

    localparam int EDGE_W = $clog2(2 * DATA_W);

    // The counter only ever reaches i_div, so H = 2^DIV_W fits in DIV_W bits.
    logic [DIV_W-1:0]  r_cnt;
    logic [EDGE_W-1:0] r_edge;
    logic              w_tick;

    assign w_tick = i_run && (r_cnt == i_div);

    always_ff @(posedge i_clk) begin
        if (i_reset || !i_run) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Even edge indices move SCLK away from CPOL (leading), odd ones back.
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_edge_en) begin
            r_edge <= '0;
        end else if (w_tick) begin
            r_edge <= r_edge + 1'b1;
        end
    end

    assign o_tick  = w_tick;
    assign o_lead  = w_tick && i_edge_en && !r_edge[0];
    assign o_trail = w_tick && i_edge_en &&  r_edge[0];
    assign o_last  = w_tick && i_edge_en && (r_edge == EDGE_W'(2 * DATA_W - 1));

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised full-duplex SPI master, all four modes, runtime divider.
//   i_clk, i_reset : system clock, synchronous active-high reset
//   i_start        : transfer request, accepted only in IDLE
//   i_data         : transmit word (MSB first)
//   i_cs_sel       : chip-select index; out-of-range selects nothing
//   i_cpol/i_cpha  : SPI mode
//   i_div          : half period H = i_div + 1 system clocks
//   i_miso         : serial input from the slave
//   o_mosi, o_sclk : serial output and SPI clock
//   o_cs_n         : active-low chip selects
//   o_busy/o_done  : transfer in progress / one-cycle completion pulse
//   o_rdata        : received word, updated with o_done
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 2,
    parameter int DIV_W  = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic [DATA_W-1:0]             i_data,
    input  logic [clog2_min1(NUM_CS)-1:0] i_cs_sel,
    input  logic                          i_cpol,
    input  logic                          i_cpha,
    input  logic [DIV_W-1:0]              i_div,
    input  logic                          i_miso,
    output logic                          o_mosi,
    output logic                          o_sclk,
    output logic [NUM_CS-1:0]             o_cs_n,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [DATA_W-1:0]             o_rdata
);

    localparam int SEL_W = clog2_min1(NUM_CS);

    state_t            r_state;
    state_t            w_next;
    logic              r_cpha;
    logic [DIV_W-1:0]  r_div;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [NUM_CS-1:0] w_cs_dec;
    logic              w_tick;
    logic              w_lead;
    logic              w_trail;
    logic              w_last;
    logic              w_shift;
    logic              w_sample;

    spi_clk_gen #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) u_clk_gen (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_run     (r_state != IDLE),
        .i_edge_en (r_state == XFER),
        .i_div     (r_div),
        .o_tick    (w_tick),
        .o_lead    (w_lead),
        .o_trail   (w_trail),
        .o_last    (w_last)
    );

    // CPHA=0 samples on leading edges and shifts on trailing; CPHA=1 swaps.
    assign w_shift  = r_cpha ? w_lead  : w_trail;
    assign w_sample = r_cpha ? w_trail : w_lead;

    always_comb begin
        w_cs_dec = {NUM_CS{1'b1}};
        for (int i = 0; i < NUM_CS; i++) begin
            if (i_cs_sel == SEL_W'(i)) begin
                w_cs_dec[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (i_start) w_next = SETUP;
            SETUP:   if (w_tick)  w_next = XFER;
            XFER:    if (w_last)  w_next = HOLD;
            HOLD:    if (w_tick)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cpha  <= 1'b0;
            r_div   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            o_mosi  <= 1'b0;
            o_sclk  <= 1'b0;
            o_cs_n  <= {NUM_CS{1'b1}};
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_rdata <= '0;
        end else begin
            o_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    o_sclk <= i_cpol;
                    if (i_start) begin
                        r_cpha <= i_cpha;
                        r_div  <= i_div;
                        // MSB goes out now; CPHA=1 re-drives it on the first
                        // leading edge, so only CPHA=0 pre-consumes it.
                        r_tx   <= i_cpha ? i_data : (i_data << 1);
                        o_mosi <= i_data[DATA_W-1];
                        r_rx   <= '0;
                        o_cs_n <= w_cs_dec;
                        o_busy <= 1'b1;
                    end
                end
                XFER: begin
                    if (w_tick) begin
                        o_sclk <= ~o_sclk;
                    end
                    if (w_shift) begin
                        o_mosi <= r_tx[DATA_W-1];
                        r_tx   <= r_tx << 1;
                    end
                    if (w_sample) begin
                        r_rx <= {r_rx[DATA_W-2:0], i_miso};
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        o_cs_n  <= {NUM_CS{1'b1}};
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        o_rdata <= r_rx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench for spi_master_multi (DATA_W=8, NUM_CS=3, DIV_W=8).
// A behavioural slave and per-transfer monitor derive every expectation
// from the protocol rules: transfer length, edge timing, bit order, CS.
module tb_spi_master_multi;
    import spi_pkg::*;

    localparam int DW  = 8;
    localparam int NCS = 3;
    localparam int DVW = 8;

    logic           clk = 1'b0;
    logic           i_reset = 1'b1;
    logic           i_start = 1'b0;
    logic [DW-1:0]  i_data = '0;
    logic [1:0]     i_cs_sel = '0;
    logic           i_cpol = 1'b0;
    logic           i_cpha = 1'b0;
    logic [DVW-1:0] i_div = '0;
    logic           w_miso;
    logic           o_mosi, o_sclk, o_busy, o_done;
    logic [NCS-1:0] o_cs_n;
    logic [DW-1:0]  o_rdata;

    logic loopback = 1'b0;
    logic s_miso   = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    assign w_miso = loopback ? o_mosi : s_miso;

    spi_master_multi #(.DATA_W(DW), .NUM_CS(NCS), .DIV_W(DVW)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_data(i_data),
        .i_cs_sel(i_cs_sel), .i_cpol(i_cpol), .i_cpha(i_cpha), .i_div(i_div),
        .i_miso(w_miso), .o_mosi(o_mosi), .o_sclk(o_sclk), .o_cs_n(o_cs_n),
        .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One selected line low, or none when the index is out of range.
    function automatic logic [NCS-1:0] exp_cs(input logic [1:0] s);
        logic [NCS-1:0] v;
        v = '1;
        if (int'(s) < NCS) v[s] = 1'b0;
        return v;
    endfunction

    // Runs one transfer and checks it. Entered/left at a negedge.
    task automatic xfer(input string tag, input logic [DW-1:0] d, input logic [1:0] s,
                        input logic [1:0] mode, input logic [DVW-1:0] dv,
                        input logic [DW-1:0] slv, input logic lb,
                        input int pre_idle, input logic perturb);
        logic pol, pha, prev_sclk, prev_mosi, lead, edge_now, finished, sclk_at_done;
        logic [DW-1:0] mosi_cap, rdata_obs;
        logic [NCS-1:0] cs_at_done;
        int H, explen, c, k, gap;
        int busy_first, busy_cnt, done_cnt, done_c, edges, first_edge, last_edge;
        int min_gap, max_gap, cs_bad, mosi_bad;
        pol = mode[1]; pha = mode[0];
        H = int'(dv) + 1;
        explen = (2 * DW + 2) * H;
        @(posedge clk); #1;
        i_data = d; i_cs_sel = s; i_cpol = pol; i_cpha = pha; i_div = dv;
        loopback = lb;
        s_miso = slv[DW-1];
        if (pre_idle > 0) begin
            repeat (pre_idle) begin @(posedge clk); #1; end
            @(negedge clk);
            chk({tag, ".idle_sclk"}, 32'(o_sclk), 32'(pol));
            chk({tag, ".idle_busy"}, 32'(o_busy), 32'd0);
            @(posedge clk); #1;
        end
        i_start = 1'b1;
        busy_first = -1; busy_cnt = 0; done_cnt = 0; done_c = -1; edges = 0;
        first_edge = -1; last_edge = 0; min_gap = 1000000; max_gap = 0;
        cs_bad = 0; mosi_bad = 0; mosi_cap = '0; rdata_obs = '0;
        cs_at_done = '0; sclk_at_done = 1'bx; prev_sclk = 1'b0; prev_mosi = 1'b0;
        finished = 1'b0; c = 0;
        while (!finished && c <= explen + 20) begin
            @(negedge clk);
            lead = 1'b0;
            if (o_busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = c;
                if (o_cs_n !== exp_cs(s)) cs_bad++;
            end
            if (o_done) begin
                done_cnt++; done_c = c; rdata_obs = o_rdata;
                cs_at_done = o_cs_n; sclk_at_done = o_sclk; finished = 1'b1;
            end
            edge_now = (c > 0) && (o_sclk !== prev_sclk);
            if (edge_now) begin
                edges++;
                if (first_edge < 0) first_edge = c;
                else begin
                    gap = c - last_edge;
                    if (gap < min_gap) min_gap = gap;
                    if (gap > max_gap) max_gap = gap;
                end
                last_edge = c;
                lead = (o_sclk !== pol);
                if (pha == lead ? 1'b0 : 1'b1) begin
                    // sampling edge of this mode: capture what the slave sees
                    mosi_cap = {mosi_cap[DW-2:0], o_mosi};
                end
                if (!pha && !lead) begin
                    k = edges / 2;
                    if (k < DW) s_miso = slv[DW-1-k];
                end
                if (pha && lead) begin
                    k = (edges - 1) / 2;
                    s_miso = slv[DW-1-k];
                end
            end
            if (c >= 2 && o_mosi !== prev_mosi && !(edge_now && (pha ? lead : !lead)))
                mosi_bad++;
            prev_sclk = o_sclk;
            prev_mosi = o_mosi;
            if (!finished) begin
                @(posedge clk); #1;
                c++;
                if (c == 1) i_start = 1'b0;
                if (perturb && c == explen / 2) begin
                    i_start = 1'b1; i_data = ~d; i_cs_sel = s ^ 2'd1;
                    i_cpol = ~pol; i_cpha = ~pha; i_div = dv ^ 8'h05;
                end
                if (perturb && c == explen / 2 + 1) i_start = 1'b0;
            end
        end
        i_data = d; i_cs_sel = s; i_cpol = pol; i_cpha = pha; i_div = dv;
        chk({tag, ".busy_first"}, 32'(busy_first), 32'd1);
        chk({tag, ".busy_len"},   32'(busy_cnt),   32'(explen));
        chk({tag, ".done_cycle"}, 32'(done_c),     32'(explen + 1));
        chk({tag, ".done_cnt"},   32'(done_cnt),   32'd1);
        chk({tag, ".edges"},      32'(edges),      32'(2 * DW));
        chk({tag, ".first_edge"}, 32'(first_edge), 32'(2 * H + 1));
        chk({tag, ".min_gap"},    32'(min_gap),    32'(H));
        chk({tag, ".max_gap"},    32'(max_gap),    32'(H));
        chk({tag, ".mosi_word"},  32'(mosi_cap),   32'(d));
        chk({tag, ".mosi_timing"},32'(mosi_bad),   32'd0);
        chk({tag, ".rdata"},      32'(rdata_obs),  32'(lb ? d : slv));
        chk({tag, ".cs_busy"},    32'(cs_bad),     32'd0);
        chk({tag, ".cs_done"},    32'(cs_at_done), 32'((1 << NCS) - 1));
        chk({tag, ".sclk_done"},  32'(sclk_at_done), 32'(pol));
    endtask

    initial begin
        logic [DW-1:0] rd, rs;
        logic [1:0] rm, rsel;
        logic [DVW-1:0] rdv;
        int dcnt;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.cs_n",  32'(o_cs_n),  32'((1 << NCS) - 1));
        chk("rst.busy",  32'(o_busy),  32'd0);
        chk("rst.done",  32'(o_done),  32'd0);
        chk("rst.sclk",  32'(o_sclk),  32'd0);
        chk("rst.mosi",  32'(o_mosi),  32'd0);
        chk("rst.rdata", 32'(o_rdata), 32'd0);
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);

        // Mode 0 loopback, then the other modes against the slave
        xfer("m0_loop", 8'hA5, 2'd0, MODE0, 8'd1, 8'h00, 1'b1, 2, 1'b0);
        xfer("m1",      8'hC5, 2'd1, MODE1, 8'd1, 8'h3C, 1'b0, 2, 1'b0);
        xfer("m2",      8'h5A, 2'd2, MODE2, 8'd1, 8'h3C, 1'b0, 2, 1'b0);
        xfer("m3",      8'h0F, 2'd0, MODE3, 8'd1, 8'h3C, 1'b0, 2, 1'b0);

        // Divider extremes
        xfer("div0",    8'h96, 2'd0, MODE0, 8'd0,   8'h69, 1'b0, 2, 1'b0);
        xfer("div255",  8'hE1, 2'd1, MODE2, 8'hFF,  8'hC3, 1'b0, 2, 1'b0);

        // Mid-transfer start/config changes ignored; then back-to-back
        xfer("perturb", 8'h6B, 2'd0, MODE1, 8'd2, 8'h9D, 1'b0, 2, 1'b1);
        xfer("after_p", 8'h27, 2'd1, MODE1, 8'd2, 8'h4E, 1'b0, 3, 1'b0);
        xfer("b2b",     8'h81, 2'd1, MODE1, 8'd2, 8'h7E, 1'b0, 0, 1'b0);

        // Reset during XFER aborts without o_done
        @(posedge clk); #1;
        i_cpol = 1'b0; i_cpha = 1'b0; i_div = 8'd1; i_data = 8'h5A; i_cs_sel = 2'd1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);
        chk("abort.cs_n",  32'(o_cs_n),  32'((1 << NCS) - 1));
        chk("abort.busy",  32'(o_busy),  32'd0);
        chk("abort.sclk",  32'(o_sclk),  32'd0);
        chk("abort.rdata", 32'(o_rdata), 32'd0);
        chk("abort.mosi",  32'(o_mosi),  32'd0);
        dcnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (o_done || o_busy) dcnt++;
        end
        chk("abort.no_done", 32'(dcnt), 32'd0);
        xfer("post_rst", 8'h3A, 2'd0, MODE0, 8'd1, 8'hB4, 1'b0, 1, 1'b0);

        // Out-of-range chip select
        xfer("cs_oor", 8'hD2, 2'd3, MODE0, 8'd1, 8'h1F, 1'b0, 2, 1'b0);

        // Randomised transfers
        for (int n = 0; n < 6; n++) begin
            rd   = DW'($urandom);
            rs   = DW'($urandom);
            rm   = 2'($urandom_range(0, 3));
            rsel = 2'($urandom_range(0, 3));
            rdv  = DVW'($urandom_range(0, 3));
            xfer($sformatf("rand%0d", n), rd, rsel, rm, rdv, rs, 1'b0, 2, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
